// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg -- shared definitions for the instruction controller.
//   state_t      : controller FSM states (one state per clock)
//   instr_cls_t  : decoded instruction class
//   OPC_* / OP_* : opcode[15:13] and op[12:11] encodings
//   VSEL_*       : write-back source select encodings
//   ctrl_out_t   : bundle of all controller outputs (registered as one unit)
//   sext8()      : sign-extension helper for imm8
// ----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_COMPUTE   = 3'd4,
    ST_WRITE_IMM = 3'd5,
    ST_WRITE_REG = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } instr_cls_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  vsel;
    logic [1:0]  alu_op;
    logic [1:0]  shift;
    logic [15:0] sximm8;
  } ctrl_out_t;

  // Output values while idle in reset: ready high, every strobe and field low.
  localparam ctrl_out_t CTRL_OUT_RST = '{
    w:        1'b1,
    readnum:  3'd0,
    writenum: 3'd0,
    write:    1'b0,
    loada:    1'b0,
    loadb:    1'b0,
    loadc:    1'b0,
    loads:    1'b0,
    asel:     1'b0,
    vsel:     2'b00,
    alu_op:   2'b00,
    shift:    2'b00,
    sximm8:   16'h0000
  };

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_dec.sv
// ----------------------------------------------------------------------------
// instr_dec -- purely combinational field extraction and legality check.
// Ports:
//   instr   in  16  instruction word
//   rn      out  3  instr[10:8]
//   rd      out  3  instr[7:5]
//   rm      out  3  instr[2:0]
//   sh      out  2  instr[4:3]
//   op      out  2  instr[12:11]
//   sximm8  out 16  sign-extended instr[7:0]
//   cls     out  3  instruction class (CLS_ILLEGAL for unsupported encodings)
// ----------------------------------------------------------------------------
module instr_dec
  import ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [1:0]  op,
  output logic [15:0] sximm8,
  output instr_cls_t  cls
);

  logic [2:0] opcode;

  assign opcode = instr[15:13];
  assign op     = instr[12:11];
  assign rn     = instr[10:8];
  assign rd     = instr[7:5];
  assign sh     = instr[4:3];
  assign rm     = instr[2:0];
  assign sximm8 = sext8(instr[7:0]);

  // Classify the opcode/op pair; anything outside the supported set is illegal.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        case (op)
          OP_MOV_IMM: cls = CLS_MOV_IMM;
          OP_MOV_REG: cls = CLS_MOV_REG;
          default:    cls = CLS_ILLEGAL;
        endcase
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  cls = CLS_ADD;
          OP_CMP:  cls = CLS_CMP;
          OP_AND:  cls = CLS_AND;
          OP_MVN:  cls = CLS_MVN;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/instr_ctrl.sv
// ----------------------------------------------------------------------------
// instr_ctrl -- multi-cycle controller for a simple load/store datapath.
// Holds one instruction and sequences the regfile/ALU enables for it.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   s                   start strobe (sampled only in WAIT)
//   instr[15:0]         instruction word captured on start
//   w                   ready (1 only in WAIT)
//   readnum, writenum   regfile read / write selects
//   write               regfile write enable
//   loada/b/c, loads    datapath A, B, C and status enables
//   asel, bsel          operand selects (bsel is always 0)
//   vsel[1:0]           write-back source (00 = C, 10 = sximm8)
//   sximm8[15:0]        sign-extended imm8 of held instruction
//   shift[1:0]          shift field of held instruction
//   ALUop[1:0]          ALU operation
// Outputs are registered from the next state so they remain pure Moore
// functions of the state register yet come straight out of flops.
// ----------------------------------------------------------------------------
module instr_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [15:0] sximm8,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  state_t     state_r;
  state_t     state_nxt;
  logic [15:0] instr_r;
  logic [15:0] instr_nxt;
  ctrl_out_t  out_r;
  ctrl_out_t  out_nxt;

  logic [2:0]  dec_rn;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_rm;
  logic [1:0]  dec_sh;
  logic [1:0]  dec_op;
  logic [15:0] dec_sximm8;
  instr_cls_t  dec_cls;

  // Instruction register input: only a start in WAIT replaces the held word.
  always_comb begin
    instr_nxt = instr_r;
    if ((state_r == ST_WAIT) && s) begin
      instr_nxt = instr;
    end else begin
      instr_nxt = instr_r;
    end
  end

  // Decoding instr_nxt serves both next-state (equals instr_r outside WAIT)
  // and the pre-registered output fields.
  instr_dec u_dec (
    .instr  (instr_nxt),
    .rn     (dec_rn),
    .rd     (dec_rd),
    .rm     (dec_rm),
    .sh     (dec_sh),
    .op     (dec_op),
    .sximm8 (dec_sximm8),
    .cls    (dec_cls)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = ST_WAIT;
    case (state_r)
      ST_WAIT: begin
        if (s) begin
          state_nxt = ST_DECODE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_MOV_IMM:                 state_nxt = ST_WRITE_IMM;
          CLS_ADD, CLS_CMP, CLS_AND:   state_nxt = ST_GET_A;
          CLS_MOV_REG, CLS_MVN:        state_nxt = ST_GET_B;
          default:                     state_nxt = ST_WAIT;
        endcase
      end
      ST_GET_A:   state_nxt = ST_GET_B;
      ST_GET_B:   state_nxt = ST_COMPUTE;
      ST_COMPUTE: begin
        if (dec_cls == CLS_CMP) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_WRITE_REG;
        end
      end
      ST_WRITE_IMM: state_nxt = ST_WAIT;
      ST_WRITE_REG: state_nxt = ST_WAIT;
      default:      state_nxt = ST_WAIT;
    endcase
  end

  // Output decode for the state about to be entered.
  always_comb begin
    out_nxt        = CTRL_OUT_RST;
    out_nxt.w      = 1'b0;
    out_nxt.shift  = dec_sh;
    out_nxt.sximm8 = dec_sximm8;
    case (state_nxt)
      ST_WAIT: out_nxt.w = 1'b1;
      ST_DECODE: out_nxt.w = 1'b0;
      ST_GET_A: begin
        out_nxt.readnum = dec_rn;
        out_nxt.loada   = 1'b1;
      end
      ST_GET_B: begin
        out_nxt.readnum = dec_rm;
        out_nxt.loadb   = 1'b1;
      end
      ST_COMPUTE: begin
        out_nxt.loadc = 1'b1;
        // MOV reg passes B through the adder with A forced to zero.
        if (dec_cls == CLS_MOV_REG) begin
          out_nxt.alu_op = 2'b00;
        end else begin
          out_nxt.alu_op = dec_op;
        end
        out_nxt.asel  = (dec_cls == CLS_MOV_REG) || (dec_cls == CLS_MVN);
        out_nxt.loads = (dec_cls == CLS_CMP);
      end
      ST_WRITE_REG: begin
        out_nxt.write    = 1'b1;
        out_nxt.writenum = dec_rd;
        out_nxt.vsel     = VSEL_C;
      end
      ST_WRITE_IMM: begin
        out_nxt.write    = 1'b1;
        out_nxt.writenum = dec_rn;
        out_nxt.vsel     = VSEL_IMM;
      end
      default: out_nxt.w = 1'b0;
    endcase
  end

  // State, held instruction and output registers; reset aborts any instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_WAIT;
      instr_r <= 16'h0000;
      out_r   <= CTRL_OUT_RST;
    end else begin
      state_r <= state_nxt;
      instr_r <= instr_nxt;
      out_r   <= out_nxt;
    end
  end

  assign w        = out_r.w;
  assign readnum  = out_r.readnum;
  assign writenum = out_r.writenum;
  assign write    = out_r.write;
  assign loada    = out_r.loada;
  assign loadb    = out_r.loadb;
  assign loadc    = out_r.loadc;
  assign loads    = out_r.loads;
  assign asel     = out_r.asel;
  assign bsel     = 1'b0;
  assign vsel     = out_r.vsel;
  assign sximm8   = out_r.sximm8;
  assign shift    = out_r.shift;
  assign ALUop    = out_r.alu_op;

endmodule

// File: tb/tb_instr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_instr_ctrl -- directed bench for instr_ctrl. Inputs change just after a
// falling edge; outputs are checked on falling edges, away from the rising
// edge where the controller updates.
// Strobe vector order: {write, loada, loadb, loadc, loads, asel, bsel}.
// ----------------------------------------------------------------------------
module tb_instr_ctrl;

  logic        clk;
  logic        reset_n;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [15:0] sximm8;
  logic [1:0]  shift;
  logic [1:0]  alu_op;

  int vectors;
  int miscompares;

  logic [6:0] strb;
  assign strb = {write, loada, loadb, loadc, loads, asel, bsel};

  instr_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .instr    (instr),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .sximm8   (sximm8),
    .shift    (shift),
    .ALUop    (alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    s           = 1'b0;
    instr       = 16'h0000;

    // Reset state
    tick();
    chk("rst_w", {15'd0, w}, 16'h0001);
    chk("rst_strb", {9'd0, strb}, 16'h0000);
    chk("rst_fields", {4'd0, readnum, writenum, vsel, alu_op, shift}, 16'h0000);
    chk("rst_sximm8", sximm8, 16'h0000);
    #2 reset_n = 1'b1;
    tick();
    chk("idle_w", {15'd0, w}, 16'h0001);

    // MOV R3,#42
    s = 1'b1; instr = 16'hD32A;
    tick();
    s = 1'b0; instr = 16'h0000;
    chk("movi_dec_w", {15'd0, w}, 16'h0000);
    chk("movi_dec_strb", {9'd0, strb}, 16'h0000);
    tick();
    chk("movi_wr_strb", {9'd0, strb}, 16'h0040);
    chk("movi_wr_writenum", {13'd0, writenum}, 16'h0003);
    chk("movi_wr_vsel", {14'd0, vsel}, 16'h0002);
    chk("movi_wr_sximm8", sximm8, 16'h002A);
    chk("movi_wr_w", {15'd0, w}, 16'h0000);
    tick();
    chk("movi_done_w", {15'd0, w}, 16'h0001);
    chk("movi_done_strb", {9'd0, strb}, 16'h0000);

    // MOV R0,#-1
    s = 1'b1; instr = 16'hD0FF;
    tick();
    s = 1'b0;
    tick();
    chk("movn_sximm8", sximm8, 16'hFFFF);
    chk("movn_writenum", {13'd0, writenum}, 16'h0000);
    chk("movn_strb", {9'd0, strb}, 16'h0040);
    tick();
    chk("movn_done_w", {15'd0, w}, 16'h0001);

    // ADD R2,R1,R0 LSL#1
    s = 1'b1; instr = 16'hA148;
    tick();
    s = 1'b0;
    chk("add_dec_strb", {9'd0, strb}, 16'h0000);
    tick();
    chk("add_geta_strb", {9'd0, strb}, 16'h0020);
    chk("add_geta_readnum", {13'd0, readnum}, 16'h0001);
    tick();
    chk("add_getb_strb", {9'd0, strb}, 16'h0010);
    chk("add_getb_readnum", {13'd0, readnum}, 16'h0000);
    tick();
    chk("add_comp_strb", {9'd0, strb}, 16'h0008);
    chk("add_comp_aluop", {14'd0, alu_op}, 16'h0000);
    chk("add_comp_shift", {14'd0, shift}, 16'h0001);
    tick();
    chk("add_wr_strb", {9'd0, strb}, 16'h0040);
    chk("add_wr_writenum", {13'd0, writenum}, 16'h0002);
    chk("add_wr_vsel", {14'd0, vsel}, 16'h0000);
    chk("add_wr_w", {15'd0, w}, 16'h0000);
    tick();
    chk("add_done_w", {15'd0, w}, 16'h0001);

    // CMP R1,R0
    s = 1'b1; instr = 16'hA900;
    tick();
    s = 1'b0;
    tick();
    chk("cmp_geta_strb", {9'd0, strb}, 16'h0020);
    tick();
    chk("cmp_getb_strb", {9'd0, strb}, 16'h0010);
    tick();
    chk("cmp_comp_strb", {9'd0, strb}, 16'h000C);
    chk("cmp_comp_aluop", {14'd0, alu_op}, 16'h0001);
    chk("cmp_comp_w", {15'd0, w}, 16'h0000);
    tick();
    chk("cmp_done_w", {15'd0, w}, 16'h0001);
    chk("cmp_done_strb", {9'd0, strb}, 16'h0000);

    // MVN R6,R3
    s = 1'b1; instr = 16'hB8C3;
    tick();
    s = 1'b0;
    tick();
    chk("mvn_getb_strb", {9'd0, strb}, 16'h0010);
    chk("mvn_getb_readnum", {13'd0, readnum}, 16'h0003);
    tick();
    chk("mvn_comp_strb", {9'd0, strb}, 16'h000A);
    chk("mvn_comp_aluop", {14'd0, alu_op}, 16'h0003);
    tick();
    chk("mvn_wr_strb", {9'd0, strb}, 16'h0040);
    chk("mvn_wr_writenum", {13'd0, writenum}, 16'h0006);
    tick();
    chk("mvn_done_w", {15'd0, w}, 16'h0001);

    // Reset mid-run: ADD aborted in GET_B
    s = 1'b1; instr = 16'hA148;
    tick();
    s = 1'b0;
    tick();
    tick();
    chk("abort_getb_strb", {9'd0, strb}, 16'h0010);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_w", {15'd0, w}, 16'h0001);
    chk("abort_strb", {9'd0, strb}, 16'h0000);
    tick();
    chk("abort_hold_strb", {9'd0, strb}, 16'h0000);
    chk("abort_hold_w", {15'd0, w}, 16'h0001);
    #2 reset_n = 1'b1;
    // MOV R7,R7 LSR: first edge after reset release must accept it
    s = 1'b1; instr = 16'hC0F7;
    tick();
    s = 1'b0;
    chk("post_rst_accept_w", {15'd0, w}, 16'h0000);
    chk("post_rst_no_write", {9'd0, strb}, 16'h0000);
    tick();
    chk("movr_getb_strb", {9'd0, strb}, 16'h0010);
    chk("movr_getb_readnum", {13'd0, readnum}, 16'h0007);
    tick();
    chk("movr_comp_strb", {9'd0, strb}, 16'h000A);
    chk("movr_comp_aluop", {14'd0, alu_op}, 16'h0000);
    chk("movr_comp_shift", {14'd0, shift}, 16'h0002);
    tick();
    chk("movr_wr_strb", {9'd0, strb}, 16'h0040);
    chk("movr_wr_writenum", {13'd0, writenum}, 16'h0007);
    tick();
    chk("movr_done_w", {15'd0, w}, 16'h0001);

    // Illegal 16'hE000 with s held high; changed instr must not be captured early
    s = 1'b1; instr = 16'hE000;
    tick();
    instr = 16'hD32A;
    chk("ill_dec_w", {15'd0, w}, 16'h0000);
    chk("ill_dec_strb", {9'd0, strb}, 16'h0000);
    chk("ill_dec_sximm8", sximm8, 16'h0000);
    tick();
    chk("ill_back_w", {15'd0, w}, 16'h0001);
    chk("ill_back_strb", {9'd0, strb}, 16'h0000);
    chk("ill_back_sximm8", sximm8, 16'h0000);
    tick();
    s = 1'b0;
    chk("recap_dec_w", {15'd0, w}, 16'h0000);
    tick();
    chk("recap_wr_strb", {9'd0, strb}, 16'h0040);
    chk("recap_wr_sximm8", sximm8, 16'h002A);
    chk("recap_wr_writenum", {13'd0, writenum}, 16'h0003);
    tick();
    chk("recap_done_w", {15'd0, w}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
